// File: rtl/mode_exec.sv
// Consumer of the READY/SET/GO mode stream: arms, captures a count, runs a
// countdown on GO and pulses done on completion, flagging out-of-order codes.
module mode_exec #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode_valid,
    input  logic [2:0]       mode_code,
    output logic             mode_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic             done,
    output logic             err,
    input  logic             err_clr
);

    localparam logic [2:0] CODE_READY = 3'b101;
    localparam logic [2:0] CODE_SET   = 3'b010;
    localparam logic [2:0] CODE_GO    = 3'b110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t state;
    logic   loaded;
    logic   accept;
    logic   err_set;

    assign mode_ready = (state == IDLE) || (state == ARMED);
    assign busy       = (state == RUN) || (state == FINISH);
    assign accept     = mode_valid && mode_ready;

    // Any accepted code that is illegal or out of order for the current state.
    always_comb begin
        err_set = 1'b0;
        if (accept) begin
            case (state)
                IDLE: err_set = (mode_code != CODE_READY);
                ARMED: begin
                    case (mode_code)
                        CODE_READY: err_set = 1'b0;
                        CODE_SET:   err_set = 1'b0;
                        CODE_GO:    err_set = !loaded;
                        default:    err_set = 1'b1;
                    endcase
                end
                default: err_set = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            loaded <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept && (mode_code == CODE_READY)) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (accept) begin
                        if (mode_code == CODE_SET) begin
                            count  <= load_data;
                            loaded <= 1'b1;
                        end else if ((mode_code == CODE_GO) && loaded) begin
                            // A zero count skips straight to completion.
                            if (count == '0) begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end
                end
                RUN: begin
                    count <= count - WIDTH'(1);
                    if (count == WIDTH'(1)) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    loaded <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mode_exec.md
Name: mode_exec

Overview:
- Downstream consumer of the READY/SET/GO mode-control stream produced by the three-state sequencer.
- Arms on READY, captures a count payload on SET, and on GO runs a countdown, then pulses done.
- Provides a valid/ready handshake toward the sequencer and a sticky error flag for illegal or out-of-order codes.
- Feeds done/busy status back to the sequencer and system control.

Parameters:
WIDTH, 8, width of the load payload and the countdown counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
mode_valid  input  1  mode_code is valid this cycle
mode_code  input  3  READY=3'b101, SET=3'b010, GO=3'b110; any other value is illegal
mode_ready  output  1  block accepts a code this cycle
load_data  input  WIDTH  payload captured on an accepted SET
busy  output  1  countdown in progress (RUN or FINISH)
count  output  WIDTH  current countdown value (registered)
done  output  1  one-cycle pulse at countdown completion (registered)
err  output  1  sticky error flag
err_clr  input  1  synchronous clear of err

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, count=0, loaded=0, done=0, err=0. Therefore mode_ready=1 and busy=0 out of reset.
- Accept rule: a code is accepted when mode_valid && mode_ready. Nothing is consumed when mode_ready=0; upstream holds the code.
- mode_ready=1 in IDLE and ARMED, 0 in RUN and FINISH. busy=1 in RUN and FINISH. Both decode combinationally from state.
- IDLE:
  - accepted READY -> ARMED.
  - accepted SET, GO, or illegal code -> err<=1, stay IDLE, count unchanged.
- ARMED:
  - accepted SET -> count<=load_data, loaded<=1, stay ARMED. Repeated SETs overwrite; the last one wins.
  - accepted READY -> no-op, stay ARMED.
  - accepted GO with loaded=1 -> RUN if count!=0; FINISH if count==0.
  - accepted GO with loaded=0 -> err<=1, stay ARMED.
  - accepted illegal code -> err<=1, stay ARMED.
- RUN:
  - count<=count-1 every cycle.
  - When count==1 the next state is FINISH (count becomes 0).
  - Inputs are ignored.
- FINISH (one cycle): done=1, loaded<=0, -> IDLE.
- Latency: if GO is accepted at cycle t with count N, done is high in cycle t+1+N. N=0 gives done at t+1. N=2^WIDTH-1 is supported; the counter never wraps.
- err behaviour:
  - err is set on any illegal acceptance listed above and holds until err_clr=1.
  - If err_clr and a new error occur in the same cycle, err stays 1 (set wins).
  - err_clr has no effect on state.
- Reset mid-RUN aborts immediately: count=0, loaded cleared, and no done pulse is emitted.
- The state register is 2-bit enumerated (IDLE, ARMED, RUN, FINISH) with a default branch to IDLE. Every combinational output has a default assignment, so no latches are inferred.

Test Plan:
- Reset, then READY; SET load_data=8'd3; GO with mode_valid held -> mode_ready drops after GO; count reads 3,2,1,0; done high exactly 4 cycles after GO accept; back to IDLE with mode_ready=1.
- READY; SET 8'd0; GO -> done the next cycle, busy high for exactly one cycle, no decrement below 0.
- GO in IDLE -> err=1, state stays IDLE. Then err_clr pulse -> err=0. Then err_clr coincident with an illegal code 3'b000 -> err stays 1.
- READY; GO with no prior SET -> err=1, stays ARMED. Then SET 8'd5; SET 8'd2; GO -> done 3 cycles after GO accept (the last SET wins).
- During RUN, drive mode_valid=1 with SET load_data=8'hFF -> no accept, count is unaffected, and the code is accepted once back in IDLE (SET in IDLE -> err=1).
- READY; SET 8'd10; GO; assert reset 3 cycles into RUN -> immediately count=0, done never pulses, mode_ready=1. After release, GO in IDLE sets err.
